// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared constants and configuration check for the pipelined ripple-carry adder
package rca_pkg;

    localparam logic SUB_MODE = 1'b1;
    localparam logic ADD_MODE = 1'b0;

    // True when WIDTH splits into STAGES equal, non-empty segments.
    function automatic bit width_ok(input int w, input int s);
        return (s >= 1) && (s <= w) && ((w % s) == 0);
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
// Ports: i_a, i_b, i_c -> o_s (sum), o_c (carry out)
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    logic w_p;

    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & w_p);

endmodule

// File: rtl/rca_segment.sv
// rtl/rca_segment.sv - combinational SEG-bit ripple-carry chain
// Ports: i_a, i_b (SEG bits), i_cin -> o_sum (SEG bits), o_cout, o_cmsb_in (carry into top bit)
module rca_segment #(
    parameter int SEG = 4
) (
    output logic [SEG-1:0] o_sum,
    output logic           o_cout,
    output logic           o_cmsb_in,
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_cin
);

    // Carries are kept as per-bit scalars so the chain is not one vector
    // feeding back into itself.
    genvar i;
    generate
        for (i = 0; i < SEG; i++) begin : g_bit
            logic w_ci;
            logic w_co;
            if (i == 0) begin : g_first
                assign w_ci = i_cin;
            end else begin : g_next
                assign w_ci = g_bit[i-1].w_co;
            end
            full_adder u_fa (
                .i_a (i_a[i]),
                .i_b (i_b[i]),
                .i_c (w_ci),
                .o_s (o_sum[i]),
                .o_c (w_co)
            );
        end
    endgenerate

    assign o_cout    = g_bit[SEG-1].w_co;
    assign o_cmsb_in = g_bit[SEG-1].w_ci;

endmodule

// File: rtl/pipelined_rca.sv
// rtl/pipelined_rca.sv - pipelined ripple-carry adder/subtractor with valid/ready streams
// Ports: i_clk, i_rst_n (async active-low); input beat i_in_valid/o_in_ready with
//        i_a, i_b, i_cin, i_sub; output beat o_out_valid/i_out_ready with o_sum, o_cout, o_ovf
module pipelined_rca
    import rca_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    generate
        if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
            $error("pipelined_rca: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
        end
    endgenerate

    // Subtraction as A + ~B + ~borrow, so Sub=1/Cin=0 yields A-B.
    logic [WIDTH-1:0] w_beff;
    logic             w_ceff;

    assign w_beff = (i_sub == SUB_MODE) ? ~i_b : i_b;
    assign w_ceff = (i_sub == SUB_MODE) ? ~i_cin : i_cin;

    // w_free[k]: stage k may load this edge (empty, or its content moves on).
    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_free;

    always_comb begin
        w_free       = '0;
        w_free[LAST] = !w_v[LAST] || i_out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            w_free[k] = !w_v[k] || w_free[k+1];
        end
    end

    assign o_in_ready = w_free[0];

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_st
            localparam int LO   = k * SEG;
            localparam int DONE = LO + SEG;

            // Operand bits not yet consumed, lowest SEG of which this stage adds.
            logic [WIDTH-LO-1:0] w_a_in;
            logic [WIDTH-LO-1:0] w_b_in;
            logic                w_c_in;
            logic                w_v_in;
            logic [DONE-1:0]     w_sum_nxt;
            logic [SEG-1:0]      w_seg_sum;
            logic                w_seg_cout;
            logic                w_seg_cmsb;

            logic                r_v;
            logic                r_c;
            logic [DONE-1:0]     r_sum;

            if (k == 0) begin : g_src
                assign w_a_in    = i_a;
                assign w_b_in    = w_beff;
                assign w_c_in    = w_ceff;
                assign w_v_in    = i_in_valid;
                assign w_sum_nxt = w_seg_sum;
            end else begin : g_src
                assign w_a_in    = g_st[k-1].g_up.r_a;
                assign w_b_in    = g_st[k-1].g_up.r_b;
                assign w_c_in    = g_st[k-1].r_c;
                assign w_v_in    = g_st[k-1].r_v;
                assign w_sum_nxt = {w_seg_sum, g_st[k-1].r_sum};
            end

            rca_segment #(
                .SEG (SEG)
            ) u_seg (
                .o_sum     (w_seg_sum),
                .o_cout    (w_seg_cout),
                .o_cmsb_in (w_seg_cmsb),
                .i_a       (w_a_in[SEG-1:0]),
                .i_b       (w_b_in[SEG-1:0]),
                .i_cin     (w_c_in)
            );

            assign w_v[k] = r_v;

            // Data only loads with a valid beat, so idle-input X never enters.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_v   <= 1'b0;
                    r_c   <= 1'b0;
                    r_sum <= '0;
                end else if (w_free[k]) begin
                    r_v <= w_v_in;
                    if (w_v_in) begin
                        r_c   <= w_seg_cout;
                        r_sum <= w_sum_nxt;
                    end
                end
            end

            if (k < LAST) begin : g_up
                logic [WIDTH-DONE-1:0] r_a;
                logic [WIDTH-DONE-1:0] r_b;

                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else if (w_free[k] && w_v_in) begin
                        r_a <= w_a_in[WIDTH-LO-1:SEG];
                        r_b <= w_b_in[WIDTH-LO-1:SEG];
                    end
                end
            end else begin : g_msb
                logic r_cmsb;

                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_cmsb <= 1'b0;
                    end else if (w_free[k] && w_v_in) begin
                        r_cmsb <= w_seg_cmsb;
                    end
                end
            end
        end
    endgenerate

    assign o_out_valid = g_st[LAST].r_v;
    assign o_sum       = g_st[LAST].r_sum;
    assign o_cout      = g_st[LAST].r_c;
    assign o_ovf       = g_st[LAST].r_c ^ g_st[LAST].g_msb.r_cmsb;

endmodule
